// File: rtl/cpu_bus_pkg.sv
// Shared definitions for the CPU external bus read/write paths.
// Contents: bus geometry constants, BRAM region select encodings and
// the read-responder state type.
package cpu_bus_pkg;

    localparam int unsigned CPU_ADDR_WIDTH = 14;
    localparam int unsigned CPU_DATA_WIDTH = 16;
    localparam int unsigned SEL_WIDTH      = 2;

    // Region select encodings carried on BRAM_SELECT
    localparam logic [SEL_WIDTH-1:0] BRAM_SELECT_CTL    = 2'd0;
    localparam logic [SEL_WIDTH-1:0] BRAM_SELECT_MOD    = 2'd1;
    localparam logic [SEL_WIDTH-1:0] BRAM_SELECT_NORMAL = 2'd2;
    localparam logic [SEL_WIDTH-1:0] BRAM_SELECT_STM    = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        DRIVE = 2'd2,
        TURN  = 2'd3
    } rd_state_t;

endpackage

// File: rtl/cpu_bus_req_edge.sv
// Registers the bus request and flags its rising edge.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   req        : qualified bus request (combinational from bus strobes)
//   start_c    : one-cycle pulse on the cycle req is first seen high
module cpu_bus_req_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic req,
    output logic start_c
);

    logic req_q;
    logic req_d;

    always_comb begin
        req_d = req;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q <= 1'b0;
        end else begin
            req_q <= req_d;
        end
    end

    // A held request never re-fires; it must drop and rise again.
    assign start_c = req & ~req_q;

endmodule

// File: rtl/cpu_bus_read_responder.sv
// Read-side responder for the CPU external bus (CPU_CKIO domain).
// Detects CPU read cycles, fetches the word from the controller BRAM and
// returns it with a registered tri-state enable for CPU_DATA.
// Ports:
//   CLK, RESET_N         : clock, async active-low reset
//   EN, RD, RDWR, WE     : bus chip select / strobes (active high)
//   BRAM_SELECT/ADDR     : region select and word address
//   BRAM_RD_EN/ADDR/DATA : controller BRAM read port
//   DATA_OUT, DATA_OE    : read data and tri-state enable for CPU_DATA
//   BUSY, RD_COUNT       : not-idle flag, completed-read counter
module cpu_bus_read_responder
    import cpu_bus_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = CPU_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH   = CPU_DATA_WIDTH,
    parameter int unsigned BRAM_LATENCY = 2,
    parameter int unsigned TURNAROUND   = 1
) (
    input  logic                  CLK,
    input  logic                  RESET_N,
    input  logic                  EN,
    input  logic                  RD,
    input  logic                  RDWR,
    input  logic                  WE,
    input  logic [SEL_WIDTH-1:0]  BRAM_SELECT,
    input  logic [ADDR_WIDTH-1:0] BRAM_ADDR,
    output logic                  BRAM_RD_EN,
    output logic [ADDR_WIDTH-1:0] BRAM_RD_ADDR,
    input  logic [DATA_WIDTH-1:0] BRAM_RD_DATA,
    output logic [DATA_WIDTH-1:0] DATA_OUT,
    output logic                  DATA_OE,
    output logic                  BUSY,
    output logic [15:0]           RD_COUNT
);

    localparam int unsigned CNT_W = 3;
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(BRAM_LATENCY);
    localparam logic [CNT_W-1:0] TURN_LAST = CNT_W'(TURNAROUND - 1);

    logic                  req_c;
    logic                  start_c;

    rd_state_t             state_q,    state_d;
    logic [CNT_W-1:0]      cnt_q,      cnt_d;
    logic                  is_ctl_q,   is_ctl_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q,  rd_addr_d;
    logic                  rd_en_q,    rd_en_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  oe_q,       oe_d;
    logic                  busy_q,     busy_d;
    logic [15:0]           rd_count_q, rd_count_d;

    // Write strobe or write direction turns the cycle into a write.
    assign req_c = EN & RD & RDWR & ~WE;

    cpu_bus_req_edge u_req_edge (
        .clk     (CLK),
        .rst_n   (RESET_N),
        .req     (req_c),
        .start_c (start_c)
    );

    // Next-state and output logic
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        is_ctl_d   = is_ctl_q;
        rd_addr_d  = rd_addr_q;
        rd_en_d    = 1'b0;
        data_out_d = data_out_q;
        oe_d       = 1'b0;
        rd_count_d = rd_count_q;

        case (state_q)
            IDLE: begin
                if (start_c) begin
                    is_ctl_d   = (BRAM_SELECT == BRAM_SELECT_CTL);
                    data_out_d = '0;
                    cnt_d      = '0;
                    state_d    = WAIT;
                    if (is_ctl_d) begin
                        rd_en_d   = 1'b1;
                        rd_addr_d = BRAM_ADDR;
                    end
                end
            end
            // Non-controller regions pass through WAIT for one cycle so
            // both paths raise OE one cycle after entering DRIVE.
            WAIT: begin
                if (!req_c) begin
                    cnt_d   = '0;
                    state_d = TURN;
                end else if (!is_ctl_q) begin
                    state_d = DRIVE;
                end else if (cnt_q == WAIT_LAST) begin
                    data_out_d = BRAM_RD_DATA;
                    state_d    = DRIVE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DRIVE: begin
                if (req_c) begin
                    oe_d = 1'b1;
                end else begin
                    rd_count_d = rd_count_q + 16'd1;
                    cnt_d      = '0;
                    state_d    = TURN;
                end
            end
            TURN: begin
                if (cnt_q == TURN_LAST) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            is_ctl_q   <= 1'b0;
            rd_addr_q  <= '0;
            rd_en_q    <= 1'b0;
            data_out_q <= '0;
            oe_q       <= 1'b0;
            busy_q     <= 1'b0;
            rd_count_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            is_ctl_q   <= is_ctl_d;
            rd_addr_q  <= rd_addr_d;
            rd_en_q    <= rd_en_d;
            data_out_q <= data_out_d;
            oe_q       <= oe_d;
            busy_q     <= busy_d;
            rd_count_q <= rd_count_d;
        end
    end

    assign BRAM_RD_EN   = rd_en_q;
    assign BRAM_RD_ADDR = rd_addr_q;
    assign DATA_OUT     = data_out_q;
    assign DATA_OE      = oe_q;
    assign BUSY         = busy_q;
    assign RD_COUNT     = rd_count_q;

endmodule

// File: tb/tb_cpu_bus_read_responder.sv
// Scoreboard bench for cpu_bus_read_responder: the driver pushes expected
// BRAM fetches and bus responses; negedge monitors pop and compare.
module tb_cpu_bus_read_responder;

    localparam int unsigned AW       = 14;
    localparam int unsigned DW       = 16;
    localparam int unsigned BRAM_LAT = 2;
    localparam int unsigned TURN_CYC = 1;

    logic          CLK = 1'b0;
    logic          RESET_N = 1'b0;
    logic          EN = 1'b0, RD = 1'b0, RDWR = 1'b0, WE = 1'b0;
    logic [1:0]    BRAM_SELECT = 2'd0;
    logic [AW-1:0] BRAM_ADDR = '0;
    logic          BRAM_RD_EN;
    logic [AW-1:0] BRAM_RD_ADDR;
    logic [DW-1:0] BRAM_RD_DATA;
    logic [DW-1:0] DATA_OUT;
    logic          DATA_OE;
    logic          BUSY;
    logic [15:0]   RD_COUNT;

    cpu_bus_read_responder #(
        .ADDR_WIDTH   (AW),
        .DATA_WIDTH   (DW),
        .BRAM_LATENCY (BRAM_LAT),
        .TURNAROUND   (TURN_CYC)
    ) dut (
        .CLK          (CLK),
        .RESET_N      (RESET_N),
        .EN           (EN),
        .RD           (RD),
        .RDWR         (RDWR),
        .WE           (WE),
        .BRAM_SELECT  (BRAM_SELECT),
        .BRAM_ADDR    (BRAM_ADDR),
        .BRAM_RD_EN   (BRAM_RD_EN),
        .BRAM_RD_ADDR (BRAM_RD_ADDR),
        .BRAM_RD_DATA (BRAM_RD_DATA),
        .DATA_OUT     (DATA_OUT),
        .DATA_OE      (DATA_OE),
        .BUSY         (BUSY),
        .RD_COUNT     (RD_COUNT)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;
    int exp_count = 0;

    typedef struct {
        logic [AW-1:0] addr;
        int            cyc;
    } fetch_t;

    typedef struct {
        logic [DW-1:0] data;
        int            rise;
        int            fall;
        bit            ctl;
        logic [AW-1:0] addr;
    } resp_t;

    fetch_t fetch_q[$];
    resp_t  resp_q[$];

    // Controller BRAM: memory array plus a fixed-latency read pipeline.
    // Outside a valid slot the read data is noise, so mistimed sampling shows.
    logic [DW-1:0] mem [1 << AW];
    logic          en_pipe   [BRAM_LAT];
    logic [AW-1:0] addr_pipe [BRAM_LAT];
    logic [DW-1:0] noise = 16'hDEAD;

    always @(posedge CLK) begin
        en_pipe[0]   <= BRAM_RD_EN;
        addr_pipe[0] <= BRAM_RD_ADDR;
        for (int i = 1; i < int'(BRAM_LAT); i++) begin
            en_pipe[i]   <= en_pipe[i-1];
            addr_pipe[i] <= addr_pipe[i-1];
        end
        noise <= DW'($urandom);
    end

    assign BRAM_RD_DATA = en_pipe[BRAM_LAT-1] ? mem[addr_pipe[BRAM_LAT-1]] : noise;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic unexpected(input string name, input logic [31:0] act);
        n_vec++;
        n_err++;
        $display("FAIL %s: got 0x%0h expected no event (cycle %0d)", name, act, cyc);
    endtask

    // Monitor: BRAM read enable pulses
    always @(negedge CLK) begin
        fetch_t f;
        if (RESET_N && BRAM_RD_EN) begin
            if (fetch_q.size() == 0) begin
                unexpected("rd_en_unexpected", 32'(BRAM_RD_ADDR));
            end else begin
                f = fetch_q.pop_front();
                chk("rd_en_cycle", 32'(cyc), 32'(f.cyc));
                chk("rd_en_addr", 32'(BRAM_RD_ADDR), 32'(f.addr));
            end
        end
    end

    // Monitor: bus responses (OE rise / fall)
    resp_t cur;
    bit    oe_prev = 1'b0;
    always @(negedge CLK) begin
        if (DATA_OE && !oe_prev) begin
            if (resp_q.size() == 0) begin
                unexpected("oe_unexpected", 32'(DATA_OUT));
            end else begin
                cur = resp_q.pop_front();
                chk("oe_rise_cycle", 32'(cyc), 32'(cur.rise));
                chk("data_out", 32'(DATA_OUT), 32'(cur.data));
                if (cur.ctl) chk("rd_addr_held", 32'(BRAM_RD_ADDR), 32'(cur.addr));
            end
        end else if (!DATA_OE && oe_prev && RESET_N) begin
            chk("oe_fall_cycle", 32'(cyc), 32'(cur.fall));
        end
        oe_prev = DATA_OE;
    end

    // Issue one bus cycle held for h edges; queues the expected outcome.
    task automatic drive_read(input logic [1:0] sel, input logic [AW-1:0] addr,
                              input int h, input logic we, input logic rdwr);
        int t0;
        int lat;
        @(posedge CLK); #1;
        EN = 1'b1; RD = 1'b1; WE = we; RDWR = rdwr;
        BRAM_SELECT = sel; BRAM_ADDR = addr;
        t0 = cyc + 1;
        if (rdwr && !we) begin
            lat = (sel == 2'd0) ? int'(BRAM_LAT) + 2 : 2;
            if (sel == 2'd0) fetch_q.push_back('{addr: addr, cyc: t0});
            if (h > 1) begin
                resp_q.push_back('{data: (sel == 2'd0) ? mem[addr] : 16'h0000,
                                   rise: t0 + lat, fall: t0 + h,
                                   ctl: (sel == 2'd0), addr: addr});
                exp_count++;
            end
        end
        @(posedge CLK); #1;
        // Address/select move after capture and must be ignored
        BRAM_SELECT = 2'($urandom);
        BRAM_ADDR   = AW'($urandom);
        repeat (h - 1) @(posedge CLK);
        #1;
        EN = 1'b0; RD = 1'b0; WE = 1'b0;
    endtask

    task automatic settle(input int n);
        repeat (n) @(posedge CLK);
        #1;
        chk("busy_idle", 32'(BUSY), 32'd0);
        chk("rd_count", 32'(RD_COUNT), 32'(exp_count % 65536));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        int h;
        int lat;
        logic [1:0]    sel;
        logic [AW-1:0] addr;

        for (int i = 0; i < (1 << AW); i++) mem[i] = DW'($urandom);
        mem[16] = 16'h1234;
        mem[1]  = 16'hAAAA;
        mem[2]  = 16'h5555;
        for (int i = 0; i < int'(BRAM_LAT); i++) en_pipe[i] = 1'b0;

        // Reset values
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_data_oe", 32'(DATA_OE), 32'd0);
        chk("rst_data_out", 32'(DATA_OUT), 32'd0);
        chk("rst_rd_en", 32'(BRAM_RD_EN), 32'd0);
        chk("rst_rd_addr", 32'(BRAM_RD_ADDR), 32'd0);
        chk("rst_busy", 32'(BUSY), 32'd0);
        chk("rst_rd_count", 32'(RD_COUNT), 32'd0);
        RESET_N = 1'b1;
        repeat (2) @(posedge CLK);

        // Controller read, held 8 edges
        drive_read(2'd0, 14'h0010, 8, 1'b0, 1'b1);
        settle(TURN_CYC + 1);
        // Non-controller region returns zero
        drive_read(2'd2, 14'h0003, 5, 1'b0, 1'b1);
        settle(TURN_CYC + 1);
        // Write-qualified strobes: no fetch, no OE
        drive_read(2'd0, 14'h0010, 4, 1'b1, 1'b1);
        settle(TURN_CYC + 1);
        drive_read(2'd0, 14'h0010, 4, 1'b0, 1'b0);
        settle(TURN_CYC + 1);
        // Abort in WAIT
        drive_read(2'd0, 14'h0020, 1, 1'b0, 1'b1);
        settle(TURN_CYC + 1);

        // Back-to-back with the strobe re-asserted during TURN
        drive_read(2'd0, 14'h0001, 6, 1'b0, 1'b1);
        @(posedge CLK); #1;
        EN = 1'b1; RD = 1'b1; RDWR = 1'b1; WE = 1'b0;
        repeat (4) @(posedge CLK);
        #1;
        EN = 1'b0; RD = 1'b0;
        settle(TURN_CYC + 1);
        drive_read(2'd0, 14'h0002, 7, 1'b0, 1'b1);
        settle(TURN_CYC + 1);

        // Asynchronous reset while driving
        @(posedge CLK); #1;
        EN = 1'b1; RD = 1'b1; RDWR = 1'b1; WE = 1'b0;
        BRAM_SELECT = 2'd0; BRAM_ADDR = 14'h0100;
        fetch_q.push_back('{addr: 14'h0100, cyc: cyc + 1});
        resp_q.push_back('{data: mem[14'h0100], rise: cyc + 1 + int'(BRAM_LAT) + 2,
                           fall: 0, ctl: 1'b1, addr: 14'h0100});
        repeat (BRAM_LAT + 4) @(posedge CLK);
        #1;
        chk("pre_rst_oe", 32'(DATA_OE), 32'd1);
        #1;
        RESET_N = 1'b0;
        #1;
        chk("mid_rst_data_oe", 32'(DATA_OE), 32'd0);
        chk("mid_rst_data_out", 32'(DATA_OUT), 32'd0);
        chk("mid_rst_busy", 32'(BUSY), 32'd0);
        chk("mid_rst_rd_count", 32'(RD_COUNT), 32'd0);
        chk("mid_rst_rd_addr", 32'(BRAM_RD_ADDR), 32'd0);
        EN = 1'b0; RD = 1'b0;
        exp_count = 0;
        @(posedge CLK); #1;
        RESET_N = 1'b1;
        settle(2);

        // Randomised traffic
        for (int n = 0; n < 150; n++) begin
            r    = int'($urandom_range(0, 7));
            sel  = (r < 4) ? 2'd0 : 2'(r - 4);
            addr = AW'($urandom);
            lat  = (sel == 2'd0) ? int'(BRAM_LAT) + 2 : 2;
            r    = int'($urandom_range(0, 9));
            if (r == 0) begin
                drive_read(sel, addr, int'($urandom_range(1, 6)), 1'b1, 1'b1);
            end else if (r == 1) begin
                drive_read(sel, addr, int'($urandom_range(1, 6)), 1'b0, 1'b0);
            end else if (r == 2) begin
                drive_read(sel, addr, 1, 1'b0, 1'b1);
            end else begin
                h = lat + 1 + int'($urandom_range(0, 5));
                drive_read(sel, addr, h, 1'b0, 1'b1);
            end
            settle(int'(TURN_CYC) + 1 + int'($urandom_range(0, 2)));
        end

        repeat (4) @(posedge CLK);
        #1;
        chk("resp_q_drained", 32'(resp_q.size()), 32'd0);
        chk("fetch_q_drained", 32'(fetch_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
